// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words with their PCs in a small skid
// FIFO and presents them to decode as a valid/stall stream. A redirect from
// execute reloads the PC, empties the buffer and drops responses in flight.
//
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   imem_req/imem_addr    request valid and byte address (current PC)
//   imem_ready            memory accepts when imem_req && imem_ready
//   imem_rvalid/rdata     in-order response stream
//   isBranchTaken/branchPC redirect strobe and target from execute
//   of_stall              decode cannot accept this cycle
//   if_valid/if_inst/if_pc buffered instruction and its PC toward decode
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        isBranchTaken,
  input  logic [31:0] branchPC,
  input  logic        of_stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;  // FIFO pointer width
  localparam int unsigned CW = PW + 1;               // counts 0..DEPTH
  localparam int unsigned LW = CW + 1;               // headroom for the sum

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occ;

  logic [31:0]   tag_mem [DEPTH];
  logic [PW-1:0] tag_wr_ptr;
  logic [PW-1:0] tag_rd_ptr;

  logic [31:0]   dpc_mem   [DEPTH];
  logic [31:0]   dinst_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          pop_c;
  logic          accept_c;
  logic          resp_c;
  logic          keep_c;
  logic          drop_c;
  logic [LW-1:0] level_c;

  // Handshake decode; a response with nothing outstanding is ignored.
  always_comb begin
    pop_c    = 1'b0;
    level_c  = '0;
    imem_req = 1'b0;
    accept_c = 1'b0;
    resp_c   = 1'b0;
    keep_c   = 1'b0;
    drop_c   = 1'b0;

    pop_c    = if_valid && !of_stall;
    // Slots still committed after this cycle's pop decide whether to ask.
    level_c  = LW'(inflight) + LW'(occ) - LW'(pop_c);
    imem_req = !reset && !isBranchTaken && (level_c < LW'(DEPTH));
    accept_c = imem_req && imem_ready;
    resp_c   = !reset && imem_rvalid && (inflight != '0);
    keep_c   = resp_c && !isBranchTaken && (drop_cnt == '0);
    drop_c   = resp_c && !isBranchTaken && (drop_cnt != '0);
  end

  // Outputs toward memory and decode; forced to reset values while in reset.
  always_comb begin
    imem_addr = RESET_PC;
    if_valid  = 1'b0;
    if_inst   = '0;
    if_pc     = '0;
    if (!reset) begin
      imem_addr = pc;
      if_valid  = (occ != '0);
      if (if_valid) begin
        if_inst = dinst_mem[rd_ptr];
        if_pc   = dpc_mem[rd_ptr];
      end
    end
  end

  // FIFO storage; entries are only meaningful through the pointers.
  always_ff @(posedge clock) begin
    if (accept_c) begin
      tag_mem[tag_wr_ptr] <= pc;
    end
    if (keep_c) begin
      dpc_mem[wr_ptr]   <= tag_mem[tag_rd_ptr];
      dinst_mem[wr_ptr] <= imem_rdata;
    end
  end

  // PC, counters and pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      inflight   <= '0;
      drop_cnt   <= '0;
      occ        <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (accept_c) begin
        tag_wr_ptr <= tag_wr_ptr + PW'(1);
        pc         <= pc + 32'd4;
      end
      if (resp_c) begin
        tag_rd_ptr <= tag_rd_ptr + PW'(1);
      end
      inflight <= inflight + CW'(accept_c) - CW'(resp_c);

      if (isBranchTaken) begin
        // Everything still outstanding after this cycle's response is stale.
        pc       <= branchPC;
        occ      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        drop_cnt <= inflight - CW'(resp_c);
      end else begin
        if (drop_c) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (keep_c) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop_c) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        occ <= occ + CW'(keep_c) - CW'(pop_c);
      end
    end
  end

endmodule
